// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/ALU op definitions plus the decode-side
// constants and the issue record handed from the decoder to the issue pipe.
package cpu_types_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } aluop_t;

    localparam logic [6:0] OPCODE_OP    = 7'b0110011;
    localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_t;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        aluop_t     op;
        word_t      a;
        word_t      b;
        logic [4:0] rd;
        logic       illegal;
    } alu_issue_t;

    localparam alu_issue_t ISSUE_NOP = '{op: ALU_ADD, a: '0, b: '0, rd: 5'd0, illegal: 1'b0};

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I OP / OP-IMM decoder producing the ALU op and operands.
// Anything not decodable becomes ADD 0,0 with the illegal bit set.
module alu_op_decode
    import cpu_types_pkg::*;
(
    input  logic [31:0] instr,
    input  word_t       rs1_data,
    input  word_t       rs2_data,
    output alu_issue_t  issue
);

    funct3_t    f3;
    logic [6:0] f7;
    word_t      imm_sext;
    word_t      rs2_shamt;
    word_t      imm_shamt;
    aluop_t     op_sel;
    word_t      b_sel;
    logic       legal;
    logic       unused_rs1_idx;

    assign f3        = funct3_t'(instr[14:12]);
    assign f7        = instr[31:25];
    assign imm_sext  = {{20{instr[31]}}, instr[31:20]};
    // The alu shifts by the whole of port_b, so the shift amount is masked here.
    assign rs2_shamt = {27'd0, rs2_data[4:0]};
    assign imm_shamt = {27'd0, instr[24:20]};
    assign unused_rs1_idx = ^instr[19:15];

    always_comb begin
        op_sel = ALU_ADD;
        b_sel  = rs2_data;
        legal  = 1'b0;
        case (instr[6:0])
            OPCODE_OP: begin
                legal = (f7 == FUNCT7_BASE);
                case (f3)
                    F3_ADD: begin
                        if (f7 == FUNCT7_ALT) begin
                            op_sel = ALU_SUB;
                            legal  = 1'b1;
                        end
                    end
                    F3_SLL: begin op_sel = ALU_SLL; b_sel = rs2_shamt; end
                    F3_SLT:  op_sel = ALU_SLT;
                    F3_SLTU: op_sel = ALU_SLTU;
                    F3_XOR:  op_sel = ALU_XOR;
                    F3_SR: begin
                        b_sel  = rs2_shamt;
                        op_sel = (f7 == FUNCT7_ALT) ? ALU_SRA : ALU_SRL;
                        legal  = (f7 == FUNCT7_BASE) || (f7 == FUNCT7_ALT);
                    end
                    F3_OR:   op_sel = ALU_OR;
                    F3_AND:  op_sel = ALU_AND;
                    default: legal = 1'b0;
                endcase
            end
            OPCODE_OPIMM: begin
                legal = 1'b1;
                b_sel = imm_sext;
                case (f3)
                    F3_ADD:  op_sel = ALU_ADD;
                    F3_SLL: begin
                        op_sel = ALU_SLL;
                        b_sel  = imm_shamt;
                        legal  = (f7 == FUNCT7_BASE);
                    end
                    F3_SLT:  op_sel = ALU_SLT;
                    F3_SLTU: op_sel = ALU_SLTU;
                    F3_XOR:  op_sel = ALU_XOR;
                    F3_SR: begin
                        b_sel  = imm_shamt;
                        op_sel = (f7 == FUNCT7_ALT) ? ALU_SRA : ALU_SRL;
                        legal  = (f7 == FUNCT7_BASE) || (f7 == FUNCT7_ALT);
                    end
                    F3_OR:   op_sel = ALU_OR;
                    F3_AND:  op_sel = ALU_AND;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        issue    = ISSUE_NOP;
        issue.rd = instr[11:7];
        if (legal) begin
            issue.op = op_sel;
            issue.a  = rs1_data;
            issue.b  = b_sel;
        end else begin
            issue.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage ALU initiator: decode register D feeds the external alu,
// result register R captures its output behind a valid/ready handshake.
module alu_issue
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [WORD_W-1:0] in_rs1_data,
    input  logic [WORD_W-1:0] in_rs2_data,
    output aluop_t            ALUOP,
    output logic [WORD_W-1:0] port_a,
    output logic [WORD_W-1:0] port_b,
    input  logic [WORD_W-1:0] port_out,
    input  logic              negative,
    input  logic              overflow,
    input  logic              zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_ovf,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_illegal
);

    alu_issue_t        dec;
    alu_issue_t        d_q, d_d;
    logic              d_valid_q, d_valid_d;
    logic              r_valid_q, r_valid_d;
    logic [WORD_W-1:0] r_result_q, r_result_d;
    logic [REG_AW-1:0] r_rd_q, r_rd_d;
    logic              r_ovf_q, r_ovf_d;
    logic              r_zero_q, r_zero_d;
    logic              r_neg_q, r_neg_d;
    logic              r_illegal_q, r_illegal_d;
    logic              d_adv;
    logic              accept;

    alu_op_decode u_dec (
        .instr    (in_instr),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .issue    (dec)
    );

    always_comb begin
        d_adv    = d_valid_q && (!r_valid_q || out_ready);
        in_ready = !flush && (!d_valid_q || d_adv);
        accept   = in_valid && in_ready;

        d_d         = d_q;
        d_valid_d   = d_valid_q;
        r_valid_d   = r_valid_q;
        r_result_d  = r_result_q;
        r_rd_d      = r_rd_q;
        r_ovf_d     = r_ovf_q;
        r_zero_d    = r_zero_q;
        r_neg_d     = r_neg_q;
        r_illegal_d = r_illegal_q;

        // Flush overrides every handshake; accept is already blocked via in_ready.
        if (flush) begin
            d_valid_d = 1'b0;
            r_valid_d = 1'b0;
        end else begin
            if (accept) begin
                d_d       = dec;
                d_valid_d = 1'b1;
            end else if (d_adv) begin
                d_valid_d = 1'b0;
            end

            if (d_adv) begin
                r_valid_d   = 1'b1;
                r_result_d  = port_out;
                r_rd_d      = d_q.rd;
                r_ovf_d     = overflow;
                r_zero_d    = zero;
                r_neg_d     = negative;
                r_illegal_d = d_q.illegal;
            end else if (out_ready) begin
                r_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_q         <= ISSUE_NOP;
            d_valid_q   <= 1'b0;
            r_valid_q   <= 1'b0;
            r_result_q  <= '0;
            r_rd_q      <= '0;
            r_ovf_q     <= 1'b0;
            r_zero_q    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_illegal_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            d_valid_q   <= d_valid_d;
            r_valid_q   <= r_valid_d;
            r_result_q  <= r_result_d;
            r_rd_q      <= r_rd_d;
            r_ovf_q     <= r_ovf_d;
            r_zero_q    <= r_zero_d;
            r_neg_q     <= r_neg_d;
            r_illegal_q <= r_illegal_d;
        end
    end

    assign ALUOP       = d_q.op;
    assign port_a      = d_q.a;
    assign port_b      = d_q.b;
    assign out_valid   = r_valid_q;
    assign out_result  = r_result_q;
    assign out_rd      = r_rd_q;
    assign out_ovf     = r_ovf_q;
    assign out_zero    = r_zero_q;
    assign out_neg     = r_neg_q;
    assign out_illegal = r_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table, hand sequences for backpressure,
// flush and reset, and a randomized stream against an instruction-level model.
module tb_alu_issue;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, flush, in_valid, in_ready, out_ready;
    logic [31:0] in_instr, in_rs1_data, in_rs2_data;
    aluop_t      ALUOP;
    logic [31:0] port_a, port_b, port_out, out_result;
    logic        negative, overflow, zero;
    logic        out_valid, out_ovf, out_zero, out_neg, out_illegal;
    logic [4:0]  out_rd;

    int checks = 0;
    int failures = 0;
    int n_acc = 0;
    int n_ret = 0;
    int valid_pct = 100;

    always #5 CLK = ~CLK;

    alu_issue #(.WORD_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .ALUOP(ALUOP), .port_a(port_a), .port_b(port_b),
        .port_out(port_out), .negative(negative), .overflow(overflow), .zero(zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_ovf(out_ovf), .out_zero(out_zero),
        .out_neg(out_neg), .out_illegal(out_illegal)
    );

    // External combinational alu: shifts use the full port_b value.
    always_comb begin
        logic [31:0] s;
        s = 32'd0;
        overflow = 1'b0;
        case (ALUOP)
            ALU_ADD: begin
                s = port_a + port_b;
                overflow = (port_a[31] == port_b[31]) && (s[31] != port_a[31]);
            end
            ALU_SUB: begin
                s = port_a - port_b;
                overflow = (port_a[31] != port_b[31]) && (s[31] != port_a[31]);
            end
            ALU_SLL:  s = port_a << port_b;
            ALU_SLT:  s = ($signed(port_a) < $signed(port_b)) ? 32'd1 : 32'd0;
            ALU_SLTU: s = (port_a < port_b) ? 32'd1 : 32'd0;
            ALU_XOR:  s = port_a ^ port_b;
            ALU_SRL:  s = port_a >> port_b;
            ALU_SRA:  s = $unsigned($signed(port_a) >>> port_b);
            ALU_OR:   s = port_a | port_b;
            ALU_AND:  s = port_a & port_b;
            default:  s = 32'd0;
        endcase
        port_out = s;
        negative = s[31];
        zero     = (s == 32'd0);
    end

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } op_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        aluop_t      op;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic        neg;
        logic        ill;
    } vec_t;

    exp_t sb[$];
    op_t  pend[$];

    // Instruction-level reference: what architectural result each instruction yields.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] r2);
        exp_t e;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        isop, isimm, alt;
        f3 = ins[14:12];
        f7 = ins[31:25];
        isop  = (ins[6:0] == 7'h33);
        isimm = (ins[6:0] == 7'h13);
        alt   = (f7 == 7'h20);
        e.rd = ins[11:7];
        e.res = 32'd0;
        e.ovf = 1'b0;
        b  = isop ? r2 : {{20{ins[31]}}, ins[31:20]};
        sh = isop ? r2[4:0] : ins[24:20];
        if (!isop && !isimm) e.ill = 1'b1;
        else if (isop) e.ill = !((f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5)));
        else e.ill = ((f3 == 3'd1) && (f7 != 7'h00)) || ((f3 == 3'd5) && (f7 != 7'h00) && !alt);
        if (!e.ill) begin
            case (f3)
                3'd0: begin
                    if (isop && alt) begin
                        e.res = a - b;
                        e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]);
                    end else begin
                        e.res = a + b;
                        e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]);
                    end
                end
                3'd1: e.res = a << sh;
                3'd2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
                3'd4: e.res = a ^ b;
                3'd5: e.res = alt ? $unsigned($signed(a) >>> sh) : (a >> sh);
                3'd6: e.res = a | b;
                default: e.res = a & b;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0] opc, f7;
        int r;
        r = $urandom_range(99);
        opc = (r < 45) ? 7'h33 : (r < 90) ? 7'h13 : 7'($urandom());
        case ($urandom_range(4))
            0, 1, 2: f7 = 7'h00;
            3:       f7 = 7'h20;
            default: f7 = 7'($urandom());
        endcase
        return {f7, 5'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()), opc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accept, compare on retire; flush/reset discard in-flight work.
    always @(negedge CLK) begin
        exp_t e;
        if (RST || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_ret++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_result", out_result, e.res);
                    check("sb_rd", 32'(out_rd), 32'(e.rd));
                    check("sb_ovf", 32'(out_ovf), 32'(e.ovf));
                    check("sb_zero", 32'(out_zero), 32'(e.res == 32'd0));
                    check("sb_neg", 32'(out_neg), 32'(e.res[31]));
                    check("sb_illegal", 32'(out_illegal), 32'(e.ill));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(ref_model(in_instr, in_rs1_data, in_rs2_data));
                n_acc++;
            end
        end
    end

    task automatic load_inputs();
        if (pend.size() > 0 && ($urandom_range(99) < valid_pct)) begin
            in_valid    = 1'b1;
            in_instr    = pend[0].instr;
            in_rs1_data = pend[0].rs1;
            in_rs2_data = pend[0].rs2;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // One clock: sample handshake mid-cycle, then re-drive just after the edge.
    task automatic step();
        logic a;
        @(negedge CLK);
        a = in_valid && in_ready;
        @(posedge CLK);
        #1;
        if (a && pend.size() > 0) void'(pend.pop_front());
        load_inputs();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        in_valid    = 1'b1;
        in_instr    = v.instr;
        in_rs1_data = v.rs1;
        in_rs2_data = v.rs2;
        @(negedge CLK);
        check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_instr = $urandom();
        check($sformatf("v%0d_aluop", idx), 32'(ALUOP), 32'(v.op));
        check($sformatf("v%0d_port_a", idx), port_a, v.ill ? 32'd0 : v.rs1);
        check($sformatf("v%0d_port_b", idx), port_b, v.b);
        check($sformatf("v%0d_valid_n1", idx), 32'(out_valid), 32'd0);
        @(posedge CLK);
        #1;
        check($sformatf("v%0d_valid_n2", idx), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_result", idx), out_result, v.res);
        check($sformatf("v%0d_rd", idx), 32'(out_rd), 32'(v.instr[11:7]));
        check($sformatf("v%0d_ovf", idx), 32'(out_ovf), 32'(v.ovf));
        check($sformatf("v%0d_zero", idx), 32'(out_zero), 32'(v.zero));
        check($sformatf("v%0d_neg", idx), 32'(out_neg), 32'(v.neg));
        check($sformatf("v%0d_illegal", idx), 32'(out_illegal), 32'(v.ill));
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check($sformatf("v%0d_drained", idx), 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_result"}, out_result, 32'd0);
        check({tag, "_out_rd"}, 32'(out_rd), 32'd0);
        check({tag, "_out_ovf"}, 32'(out_ovf), 32'd0);
        check({tag, "_out_zero"}, 32'(out_zero), 32'd0);
        check({tag, "_out_neg"}, 32'(out_neg), 32'd0);
        check({tag, "_out_illegal"}, 32'(out_illegal), 32'd0);
        check({tag, "_aluop"}, 32'(ALUOP), 32'(ALU_ADD));
        check({tag, "_port_a"}, port_a, 32'd0);
        check({tag, "_port_b"}, port_b, 32'd0);
    endtask

    vec_t tbl[16];

    initial begin
        int acc0, ret0;
        tbl[0]  = '{rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h7FFFFFFF, 32'h1, ALU_ADD, 32'h1, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{itype(12'h404, 5'd1, 3'b101, 5'd5), 32'hF0000000, 32'h0, ALU_SRA, 32'h4, 32'hFF000000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{rtype(7'h00, 5'd2, 5'd1, 3'b001, 5'd6), 32'h1, 32'h24, ALU_SLL, 32'h4, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{itype(12'hFFF, 5'd1, 3'b011, 5'd7), 32'h5, 32'h0, ALU_SLTU, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{itype(12'hFFF, 5'd1, 3'b010, 5'd8), 32'h5, 32'h0, ALU_SLT, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd9), 32'h80000000, 32'h1, ALU_SUB, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{{20'h12345, 5'd10, 7'b0110111}, 32'hDEADBEEF, 32'h1, ALU_ADD, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd11), 32'h3, 32'h4, ALU_ADD, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{itype(12'h403, 5'd1, 3'b001, 5'd12), 32'h1, 32'h0, ALU_ADD, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{itype(12'hFFF, 5'd1, 3'b000, 5'd0), 32'h1, 32'h0, ALU_ADD, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{itype(12'h800, 5'd1, 3'b100, 5'd13), 32'h0, 32'h0, ALU_XOR, 32'hFFFFF800, 32'hFFFFF800, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{rtype(7'h00, 5'd2, 5'd1, 3'b101, 5'd14), 32'h80000000, 32'hFFFFFFFF, ALU_SRL, 32'h1F, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd15), 32'hF0F0, 32'hFF00, ALU_AND, 32'hFF00, 32'hF000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{itype(12'h0F0, 5'd1, 3'b110, 5'd16), 32'hF, 32'h0, ALU_OR, 32'hF0, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{rtype(7'h20, 5'd2, 5'd1, 3'b101, 5'd17), 32'h80000000, 32'h21, ALU_SRA, 32'h1, 32'hC0000000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{rtype(7'h00, 5'd2, 5'd1, 3'b011, 5'd18), 32'h1, 32'hFFFFFFFF, ALU_SLTU, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0};

        RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_rs1_data = 32'd0; in_rs2_data = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("rst");
        check("rst_in_ready", 32'(in_ready), 32'd1);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_reset_outputs("post_rst");

        for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

        // Backpressure: R blocked, D fills, then four retire in order.
        valid_pct = 100;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            pend.push_back('{itype(12'(k + 1), 5'd1, 3'b000, 5'(k + 20)), 32'h100 * (k + 1), 32'd0});
        acc0 = n_acc; ret0 = n_ret;
        load_inputs();
        for (int c = 0; c < 4; c++) step();
        check("bp_accepts", 32'(n_acc - acc0), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_r_held", out_result, 32'h101);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (n_ret - ret0) < 4; c++) step();
        check("bp_retired", 32'(n_ret - ret0), 32'd4);
        check("bp_all_accepted", 32'(n_acc - acc0), 32'd4);

        // Flush with D and R full and a new instruction offered.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            pend.push_back('{rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'(k + 1)), 32'(k), 32'hA5});
        load_inputs();
        step();
        step();
        check("fl_pre_valid", 32'(out_valid), 32'd1);
        acc0 = n_acc; ret0 = n_ret;
        flush = 1'b1;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        pend.delete();
        in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_no_accept", 32'(n_acc - acc0), 32'd0);
        out_ready = 1'b1;
        step();
        step();
        check("fl_d_empty", 32'(out_valid), 32'd0);
        check("fl_no_retire", 32'(n_ret - ret0), 32'd0);

        // Asynchronous reset in the middle of a busy stream.
        for (int k = 0; k < 4; k++)
            pend.push_back('{itype(12'h7FF, 5'd1, 3'b111, 5'(k + 5)), 32'hFFFF_FFFF, 32'd0});
        load_inputs();
        step();
        step();
        RST = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        pend.delete();
        in_valid = 1'b0;
        @(negedge CLK);
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_reset_outputs("after_mid_rst");

        // Randomized stream against the reference model.
        valid_pct = 70;
        for (int c = 0; c < 600; c++) begin
            if (pend.size() < 4) pend.push_back('{rnd_instr(), rnd_word(), rnd_word()});
            out_ready = ($urandom_range(99) < 70);
            flush     = ($urandom_range(39) == 0);
            step();
        end
        flush = 1'b0;
        pend.delete();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (sb.size() > 0 || out_valid); c++) step();
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
